// File: rtl/gate_a_ctrl.sv
// rtl/gate_a_ctrl.sv - gate A open/close slide sequencer with frog collision reporting
//
// Ports:
//   CLK, RESETn      clock, asynchronous active-low reset
//   startOfFrame     one-cycle pulse per VGA frame
//   enable           1 = sequencing advances on frame ticks; 0 = state, Y and hold counter frozen
//   open_cmd         early-open request, honoured only while CLOSED
//   frog_draw_req    frog drawer pixel request
//   gateA_draw_req   gate drawer pixel request
//   ObjectStartX     gate X start (constant GATE_X)
//   ObjectStartY     gate Y start (registered)
//   gate_state       00 CLOSED, 01 OPENING, 10 OPEN, 11 CLOSING
//   gate_is_open     high while gate_state == OPEN
//   collision        one-cycle pulse after a frame tick if frog and gate overlapped in the previous frame
module gate_a_ctrl #(
    parameter int GATE_X             = 300,
    parameter int GATE_Y_CLOSED      = 200,
    parameter int GATE_Y_OPEN        = 190,
    parameter int STEP               = 1,
    parameter int CLOSED_HOLD_FRAMES = 60,
    parameter int OPEN_HOLD_FRAMES   = 120
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic        open_cmd,
    input  logic        frog_draw_req,
    input  logic        gateA_draw_req,
    output logic [10:0] ObjectStartX,
    output logic [10:0] ObjectStartY,
    output logic [1:0]  gate_state,
    output logic        gate_is_open,
    output logic        collision
);

    localparam int HOLD_MAX = (CLOSED_HOLD_FRAMES > OPEN_HOLD_FRAMES) ? CLOSED_HOLD_FRAMES : OPEN_HOLD_FRAMES;
    // Counter only has to reach HOLD_MAX-1.
    localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [10:0]   X_L         = 11'(GATE_X);
    localparam logic [10:0]   Y_CLOSED_L  = 11'(GATE_Y_CLOSED);
    localparam logic [10:0]   Y_OPEN_L    = 11'(GATE_Y_OPEN);
    localparam logic [10:0]   STEP_L      = 11'(STEP);
    localparam logic [CW-1:0] CLOSED_LAST = CW'(CLOSED_HOLD_FRAMES - 1);
    localparam logic [CW-1:0] OPEN_LAST   = CW'(OPEN_HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'b00,
        ST_OPENING = 2'b01,
        ST_OPEN    = 2'b10,
        ST_CLOSING = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [10:0]   y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          open_req_q, open_req_d;
    logic          hit_pending_q;
    logic          collision_q;

    logic          frame_upd;
    logic          overlap;
    logic [11:0]   y_up_sum;
    logic [10:0]   y_dn;
    logic [10:0]   y_up;

    assign frame_upd = startOfFrame & enable;
    assign overlap   = frog_draw_req & gateA_draw_req;

    // State register, including position, hold counter and collision tracking.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q       <= ST_CLOSED;
            y_q           <= Y_CLOSED_L;
            cnt_q         <= '0;
            open_req_q    <= 1'b0;
            hit_pending_q <= 1'b0;
            collision_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            y_q           <= y_d;
            cnt_q         <= cnt_d;
            open_req_q    <= open_req_d;
            // Reporting ignores enable; an overlap on the tick cycle belongs to the next frame.
            collision_q   <= startOfFrame & hit_pending_q;
            hit_pending_q <= overlap | (hit_pending_q & ~startOfFrame);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        cnt_d      = cnt_q;
        open_req_d = open_req_q | (open_cmd & (state_q == ST_CLOSED));

        // Clamped steps computed wide enough that neither direction can wrap.
        y_dn     = ({1'b0, y_q} < ({1'b0, Y_OPEN_L} + {1'b0, STEP_L})) ? Y_OPEN_L : (y_q - STEP_L);
        y_up_sum = {1'b0, y_q} + {1'b0, STEP_L};
        y_up     = (y_up_sum >= {1'b0, Y_CLOSED_L}) ? Y_CLOSED_L : y_up_sum[10:0];

        if (frame_upd) begin
            case (state_q)
                ST_CLOSED: begin
                    if ((cnt_q == CLOSED_LAST) || open_req_q) begin
                        state_d    = ST_OPENING;
                        cnt_d      = '0;
                        open_req_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_OPENING: begin
                    y_d   = y_dn;
                    cnt_d = '0;
                    if (y_dn == Y_OPEN_L) begin
                        state_d = ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    if (cnt_q == OPEN_LAST) begin
                        state_d = ST_CLOSING;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_CLOSING: begin
                    cnt_d = '0;
                    if (hit_pending_q) begin
                        // Frog was under the gate last frame: hold position and reopen.
                        state_d = ST_OPENING;
                    end else begin
                        y_d = y_up;
                        if (y_up == Y_CLOSED_L) begin
                            state_d = ST_CLOSED;
                        end
                    end
                end
                default: state_d = ST_CLOSED;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        ObjectStartX = X_L;
        ObjectStartY = y_q;
        gate_state   = state_q;
        gate_is_open = (state_q == ST_OPEN);
        collision    = collision_q;
    end

endmodule
